alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Front-end controller that sits directly upstream of the ALU.
- Parses byte frames from the UART receiver and drives the ALU operands, function code and enable.
- Captures the ALU's registered 16-bit result and serialises it, LSB first, to the UART transmitter.
- Single clock domain. Owns all ALU sequencing, so the ALU never sees partial operands.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and of ALU operands A/B.
- RES_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH, so always 2 TX bytes.
- CMD_OPS, 8'hCC, command byte: full frame CC, A, B, FUN.
- CMD_FUN, 8'hDD, command byte: short frame DD, FUN; reuses the last A/B.
- TIMEOUT, 15, maximum cycles to wait for OUT_VALID after ALU_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid in this cycle.
- ALU_OUT  in  RES_WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid; one cycle after ALU_EN.
- TX_BUSY  in  1  transmitter busy.
- ALU_A  out  DATA_WIDTH  operand A, registered.
- ALU_B  out  DATA_WIDTH  operand B, registered.
- ALU_FUN  out  4  ALU function, registered; taken from FUN byte bits [3:0].
- ALU_EN  out  1  one-cycle enable pulse.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  transmit request.
- CMD_ERR  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. ALU_A/ALU_B hold their values across frames and are cleared only by reset.
- States: IDLE, GET_A, GET_B, GET_FUN, RUN, WAIT_RES, SEND_LSB, GAP, SEND_MSB.
- IDLE, on RX_D_VLD:
  - byte == CMD_OPS -> GET_A.
  - byte == CMD_FUN -> GET_FUN.
  - any other byte -> stay in IDLE, pulse CMD_ERR next cycle.
- GET_A / GET_B: on RX_D_VLD, load ALU_A / ALU_B; advance to GET_B / GET_FUN.
- GET_FUN: on RX_D_VLD, load ALU_FUN <= byte[3:0] -> RUN. Byte bits [7:4] are ignored.
- RUN: ALU_EN = 1 for exactly this cycle; clear the timeout counter -> WAIT_RES.
- WAIT_RES:
  - OUT_VALID = 1 -> latch ALU_OUT into the result register -> SEND_LSB.
  - Counter reaches TIMEOUT without OUT_VALID -> pulse CMD_ERR -> IDLE.
- SEND_LSB: TX_P_DATA = result[7:0], TX_D_VLD = 1 while TX_BUSY = 0. The byte is accepted in the cycle where TX_D_VLD = 1 and TX_BUSY = 0 -> GAP.
- GAP: TX_D_VLD = 0 for one cycle, giving the transmitter time to raise TX_BUSY -> SEND_MSB.
- SEND_MSB: same handshake with result[15:8] -> IDLE. If TX_BUSY stays high, wait indefinitely with TX_D_VLD = 0.
- Timing:
  - Frame latency: ALU_EN is asserted 1 cycle after the RX_D_VLD of the FUN byte.
  - Result latency: SEND_LSB is entered 1 cycle after OUT_VALID.
- RX_D_VLD arriving in RUN, WAIT_RES, SEND_LSB, GAP or SEND_MSB: byte dropped, CMD_ERR pulsed, state unaffected.
- A CMD_FUN frame issued before any CMD_OPS frame since reset uses A = B = 0.
- Outputs are registered except TX_D_VLD and TX_P_DATA, which are decoded from state and the result register. TX_D_VLD must be glitch-free, meaning no combinational path from RX_P_DATA.
- Reset asserted mid-frame or mid-transmit: immediate return to IDLE, all outputs 0. A partial frame is discarded with no CMD_ERR.
- No back-to-back ALU_EN: a new frame is accepted only after SEND_MSB completes.

Decomposition:
- Shared package holds:
  - state encoding (localparams, 4-bit binary);
  - CMD_OPS and CMD_FUN byte constants;
  - the ALU function code localparams, reused by the ALU decoder and the bench.
- One natural sub-module: alu_res_serializer. It covers the SEND_LSB/GAP/SEND_MSB handshake and the result register, with a start strobe in and a done strobe out. The parsing FSM and the timeout counter stay in the top.

Test Plan:
- Full frame: RX CC,12,34,00 with ALU stub returning 0x0046 on OUT_VALID -> ALU_A=0x12, ALU_B=0x34, ALU_FUN=0, one ALU_EN pulse; TX bytes 0x46 then 0x00; no CMD_ERR.
- Short frame after the above: RX DD,01 with stub returning 0xBEEF -> ALU_A/B still 0x12/0x34, ALU_FUN=1; TX bytes 0xEF then 0xBE.
- Bad command: RX 0x55 in IDLE -> CMD_ERR pulse; then RX CC,01,02,00 completes normally.
- Timeout: stub never asserts OUT_VALID -> CMD_ERR exactly TIMEOUT+1 cycles after ALU_EN; no TX_D_VLD; next frame is accepted.
- TX backpressure: TX_BUSY held high for 40 cycles during SEND_MSB -> TX_D_VLD stays 0 and the MSB is held. Stray RX byte during the wait -> CMD_ERR, frame output unaffected.
- Reset mid-frame: RX CC,AA then RST low for 2 cycles -> all outputs 0, IDLE. A following RX 0xAA is treated as a bad command (CMD_ERR).

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer and its result serializer.
// Also holds the ALU function codes used by the ALU decoder and the bench.
package alu_cmd_sequencer_pkg;

    localparam logic [7:0] CMD_OPS_BYTE = 8'hCC;
    localparam logic [7:0] CMD_FUN_BYTE = 8'hDD;

    // ALU function codes carried in FUN byte bits [3:0]
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_MUL   = 4'h2;
    localparam logic [3:0] ALU_DIV   = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_OR    = 4'h5;
    localparam logic [3:0] ALU_NAND  = 4'h6;
    localparam logic [3:0] ALU_NOR   = 4'h7;
    localparam logic [3:0] ALU_XOR   = 4'h8;
    localparam logic [3:0] ALU_XNOR  = 4'h9;
    localparam logic [3:0] ALU_CMPEQ = 4'hA;
    localparam logic [3:0] ALU_CMPGT = 4'hB;
    localparam logic [3:0] ALU_CMPLT = 4'hC;
    localparam logic [3:0] ALU_SHR   = 4'hD;
    localparam logic [3:0] ALU_SHL   = 4'hE;

    // ST_SEND covers SEND_LSB/GAP/SEND_MSB, which the serializer sequences itself
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_A    = 4'd1,
        ST_GET_B    = 4'd2,
        ST_GET_FUN  = 4'd3,
        ST_RUN      = 4'd4,
        ST_WAIT_RES = 4'd5,
        ST_SEND     = 4'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_LSB  = 2'd1,
        SER_GAP  = 2'd2,
        SER_MSB  = 2'd3
    } ser_state_t;

endpackage

// File: rtl/alu_res_serializer.sv
// Holds the captured ALU result and sends it to the UART transmitter LSB first,
// with one idle cycle between the two bytes.
module alu_res_serializer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [RES_WIDTH-1:0]  i_result,
    input  logic                  i_tx_busy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_vld,
    output logic                  o_done
);

    ser_state_t           r_state;
    ser_state_t           w_next;
    logic [RES_WIDTH-1:0] r_res;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SER_IDLE;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == SER_IDLE && i_start) begin
                r_res <= i_result;
            end
        end
    end

    // TX_D_VLD depends only on state and TX_BUSY, never on received data
    always_comb begin
        w_next    = r_state;
        o_tx_data = '0;
        o_tx_vld  = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (i_start) begin
                    w_next = SER_LSB;
                end
            end
            SER_LSB: begin
                o_tx_data = r_res[DATA_WIDTH-1:0];
                o_tx_vld  = !i_tx_busy;
                if (!i_tx_busy) begin
                    w_next = SER_GAP;
                end
            end
            SER_GAP: begin
                w_next = SER_MSB;
            end
            SER_MSB: begin
                o_tx_data = r_res[RES_WIDTH-1 -: DATA_WIDTH];
                o_tx_vld  = !i_tx_busy;
                if (!i_tx_busy) begin
                    w_next = SER_IDLE;
                    o_done = 1'b1;
                end
            end
            default: w_next = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Parses CC/DD command frames from the UART receiver, runs the ALU once per frame
// and hands the registered result to the serializer for transmission.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RES_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_OPS    = DATA_WIDTH'(CMD_OPS_BYTE),
    parameter logic [DATA_WIDTH-1:0] CMD_FUN    = DATA_WIDTH'(CMD_FUN_BYTE),
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [RES_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t            r_state;
    seq_state_t            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_fun;
    logic                  r_alu_en;
    logic                  r_cmd_err;
    logic                  w_err;
    logic                  w_ser_start;
    logic                  w_ser_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_alu_en  <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cmd_err <= w_err;
            r_alu_en  <= (r_state == ST_GET_FUN) && RX_D_VLD;
            if (r_state == ST_GET_A && RX_D_VLD) begin
                r_alu_a <= RX_P_DATA;
            end
            if (r_state == ST_GET_B && RX_D_VLD) begin
                r_alu_b <= RX_P_DATA;
            end
            if (r_state == ST_GET_FUN && RX_D_VLD) begin
                r_alu_fun <= RX_P_DATA[3:0];
            end
            if (r_state == ST_RUN) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_RES && !OUT_VALID) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Bytes arriving while the ALU or transmitter is busy are dropped and flagged
    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        w_ser_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_OPS) begin
                        w_next = ST_GET_A;
                    end else if (RX_P_DATA == CMD_FUN) begin
                        w_next = ST_GET_FUN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_GET_A:   if (RX_D_VLD) w_next = ST_GET_B;
            ST_GET_B:   if (RX_D_VLD) w_next = ST_GET_FUN;
            ST_GET_FUN: if (RX_D_VLD) w_next = ST_RUN;
            ST_RUN: begin
                w_err  = RX_D_VLD;
                w_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                w_err = RX_D_VLD;
                if (OUT_VALID) begin
                    w_ser_start = 1'b1;
                    w_next      = ST_SEND;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_err = RX_D_VLD;
                if (w_ser_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    alu_res_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .RES_WIDTH  (RES_WIDTH)
    ) u_ser (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_start   (w_ser_start),
        .i_result  (ALU_OUT),
        .i_tx_busy (TX_BUSY),
        .o_tx_data (TX_P_DATA),
        .o_tx_vld  (TX_D_VLD),
        .o_done    (w_ser_done)
    );

    assign ALU_A   = r_alu_a;
    assign ALU_B   = r_alu_b;
    assign ALU_FUN = r_alu_fun;
    assign ALU_EN  = r_alu_en;
    assign CMD_ERR = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed frames plus randomized frames
// checked against a frame-level reference model and an ALU/UART environment stub.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_VALID = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CMD_ERR;

    alu_cmd_sequencer #(
        .DATA_WIDTH (8),
        .RES_WIDTH  (16),
        .CMD_OPS    (8'hCC),
        .CMD_FUN    (8'hDD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .TX_BUSY   (TX_BUSY),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_FUN   (ALU_FUN),
        .ALU_EN    (ALU_EN),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .CMD_ERR   (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          en_cnt = 0;
    int          err_cycle = -1;
    int          en_cycle = -1;
    int          ov_cycle = -1;
    int          lcyc = 0;
    logic [7:0]  tx_q[$];
    int          txc_q[$];
    logic        stub_en = 1'b1;
    logic        stub_fire = 1'b0;
    logic [15:0] stub_val = '0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [3:0]  m_fun = '0;

    always @(posedge CLK) cyc++;

    // Negedge view equals what the DUT samples at the next rising edge
    always @(negedge CLK) begin
        stub_fire = ALU_EN && stub_en;
        if (RST) begin
            if (TX_D_VLD && !TX_BUSY) begin
                tx_q.push_back(TX_P_DATA);
                txc_q.push_back(cyc);
            end
            if (CMD_ERR) begin
                err_cnt++;
                err_cycle = cyc;
            end
            if (ALU_EN) begin
                en_cnt++;
                en_cycle = cyc;
            end
            if (OUT_VALID) ov_cycle = cyc;
        end
    end

    // ALU stub: result valid one cycle after ALU_EN, junk on ALU_OUT otherwise
    always @(posedge CLK) begin
        #1;
        OUT_VALID = stub_fire;
        ALU_OUT   = stub_fire ? stub_val : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        lcyc      = cyc;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(tx_q.size() >= n), 32'd1);
    endtask

    function automatic logic [7:0] txb(input int i);
        return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
    endfunction

    function automatic int txc(input int i);
        return (txc_q.size() > i) ? txc_q[i] : -100;
    endfunction

    task automatic run_frame(input bit full, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fb, input logic [15:0] res, input string tag);
        int en0 = en_cnt;
        int e0  = err_cnt;
        int fcyc;
        tx_q.delete();
        txc_q.delete();
        stub_val = res;
        if (full) begin
            send_byte(CMD_OPS_BYTE);
            send_byte(a);
            send_byte(b);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(CMD_FUN_BYTE);
        end
        send_byte(fb);
        fcyc  = lcyc;
        m_fun = fb[3:0];
        wait_tx(2, {tag, "_tx_done"});
        tick();
        chk({tag, "_alu_a"}, 32'(ALU_A), 32'(m_a));
        chk({tag, "_alu_b"}, 32'(ALU_B), 32'(m_b));
        chk({tag, "_alu_fun"}, 32'(ALU_FUN), 32'(m_fun));
        chk({tag, "_tx_lsb"}, 32'(txb(0)), 32'(res[7:0]));
        chk({tag, "_tx_msb"}, 32'(txb(1)), 32'(res[15:8]));
        chk({tag, "_en_pulses"}, 32'(en_cnt - en0), 32'd1);
        chk({tag, "_no_err"}, 32'(err_cnt - e0), 32'd0);
        chk({tag, "_en_latency"}, 32'(en_cycle), 32'(fcyc + 1));
        chk({tag, "_res_latency"}, 32'(txc(0)), 32'(ov_cycle + 1));
        chk({tag, "_gap"}, 32'(txc(1)), 32'(txc(0) + 2));
    endtask

    initial begin
        int e0;
        int en0;
        int b0;
        int vs;
        int hb;
        logic [15:0] r;
        logic [7:0]  ra;
        logic [7:0]  rb;

        repeat (3) tick();
        chk("reset_outputs", 32'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}), 32'd0);
        RST = 1'b1;
        tick();

        run_frame(1'b1, 8'h12, 8'h34, {4'h0, ALU_ADD}, 16'h0046, "full");
        run_frame(1'b0, 8'h00, 8'h00, {4'h0, ALU_SUB}, 16'hBEEF, "short");

        e0 = err_cnt;
        send_byte(8'h55);
        b0 = lcyc;
        tick();
        tick();
        chk("bad_cmd_err", 32'(err_cnt - e0), 32'd1);
        chk("bad_cmd_err_time", 32'(err_cycle), 32'(b0 + 1));
        run_frame(1'b1, 8'h01, 8'h02, 8'h00, 16'h0003, "after_bad");

        stub_en = 1'b0;
        e0  = err_cnt;
        en0 = en_cnt;
        tx_q.delete();
        send_byte(CMD_OPS_BYTE);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h02);
        m_a = 8'h5A;
        m_b = 8'hA5;
        repeat (TIMEOUT + 6) tick();
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);
        chk("timeout_err_time", 32'(err_cycle), 32'(en_cycle + TIMEOUT + 1));
        chk("timeout_no_tx", 32'(tx_q.size()), 32'd0);
        chk("timeout_en", 32'(en_cnt - en0), 32'd1);
        stub_en = 1'b1;
        run_frame(1'b0, 8'h00, 8'h00, 8'hF4, 16'h1234, "after_timeout");

        r  = 16'($urandom);
        ra = 8'($urandom);
        rb = 8'($urandom);
        stub_val = r;
        tx_q.delete();
        txc_q.delete();
        send_byte(CMD_OPS_BYTE);
        send_byte(ra);
        send_byte(rb);
        send_byte(8'h07);
        m_a = ra;
        m_b = rb;
        m_fun = 4'h7;
        wait_tx(1, "bp_lsb_sent");
        TX_BUSY = 1'b1;
        tick();
        e0 = err_cnt;
        vs = 0;
        hb = 0;
        for (int i = 0; i < 39; i++) begin
            if (i == 10) send_byte(8'($urandom));
            else tick();
            if (TX_D_VLD !== 1'b0) vs++;
            if (TX_P_DATA !== r[15:8]) hb++;
        end
        chk("bp_vld_low", 32'(vs), 32'd0);
        chk("bp_msb_held", 32'(hb), 32'd0);
        chk("bp_stray_err", 32'(err_cnt - e0), 32'd1);
        chk("bp_one_byte", 32'(tx_q.size()), 32'd1);
        TX_BUSY = 1'b0;
        wait_tx(2, "bp_msb_sent");
        chk("bp_lsb", 32'(txb(0)), 32'(r[7:0]));
        chk("bp_msb", 32'(txb(1)), 32'(r[15:8]));
        chk("bp_alu_a", 32'(ALU_A), 32'(m_a));
        chk("bp_alu_b", 32'(ALU_B), 32'(m_b));
        tick();

        for (int i = 0; i < 16; i++) begin
            run_frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                      16'($urandom), "rand");
        end

        e0 = err_cnt;
        send_byte(CMD_OPS_BYTE);
        send_byte(8'hAA);
        RST = 1'b0;
        #1;
        chk("midreset_outputs", 32'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        m_a = '0;
        m_b = '0;
        tick();
        tick();
        chk("midreset_no_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'hAA);
        tick();
        chk("midreset_aa_bad", 32'(err_cnt - e0), 32'd1);
        run_frame(1'b0, 8'h00, 8'h00, 8'h03, 16'h8001, "fun_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
